iter_div_axis: RTL and testbench

Iterative radix-2 restoring divider. It is the responder side of the divide-operand stream handshake that the EX stage drives: two independent operand channels and one result channel. The EX stage instantiates one copy with SIGNED=1 for div.w/mod.w and one with SIGNED=0 for div.wu/mod.wu. It is a drop-in replacement for the vendor divider IP, with fixed latency and a single-cycle result pulse.

---
 rtl/iter_div_axis.sv | 153 +++++++++++++++
 tb/tb_iter_div_axis.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/iter_div_axis.sv
// iter_div_axis: radix-2 restoring divider with AXI-stream style operand
// channels and a single-cycle result pulse; optional signed mode.
module iter_div_axis #(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
   input  logic               s_axis_dividend_tvalid,
   output logic               s_axis_dividend_tready,
   input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
   input  logic               s_axis_divisor_tvalid,
   output logic               s_axis_divisor_tready,
   output logic [2*WIDTH-1:0] m_axis_dout_tdata,
   output logic               m_axis_dout_tvalid
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t state;
   state_t state_nx;

   logic             dvd_cap;
   logic             dvs_cap;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic             dvd_hs;
   logic             dvs_hs;
   logic             both;

   logic [WIDTH-1:0] dvd_v;
   logic [WIDTH-1:0] dvs_v;
   logic             dvd_neg;
   logic             dvs_neg;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;

   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs_m;
   logic             q_neg;
   logic             r_neg;
   logic [CW-1:0]    cnt;
   logic             last;

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;
   logic             fits;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   assign s_axis_dividend_tready = (state == IDLE) && !dvd_cap;
   assign s_axis_divisor_tready  = (state == IDLE) && !dvs_cap;

   assign dvd_hs = s_axis_dividend_tvalid && s_axis_dividend_tready;
   assign dvs_hs = s_axis_divisor_tvalid && s_axis_divisor_tready;
   assign both   = (dvd_cap || dvd_hs) && (dvs_cap || dvs_hs);

   // An operand arriving on the start edge is taken straight from the bus.
   assign dvd_v   = dvd_cap ? dvd_q : s_axis_dividend_tdata;
   assign dvs_v   = dvs_cap ? dvs_q : s_axis_divisor_tdata;
   assign dvd_neg = SIGNED && dvd_v[WIDTH-1];
   assign dvs_neg = SIGNED && dvs_v[WIDTH-1];
   assign dvd_mag = dvd_neg ? -dvd_v : dvd_v;
   assign dvs_mag = dvs_neg ? -dvs_v : dvs_v;

   // Extra top bit in diff keeps the sign unambiguous for any divisor.
   assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
   assign diff    = {1'b0, shifted} - {2'b00, dvs_m};
   assign fits    = !diff[WIDTH+1];
   assign last    = (cnt == CW'(WIDTH - 1));

   assign r_lo  = rem[WIDTH-1:0];
   assign q_fix = q_neg ? -quo : quo;
   assign r_fix = r_neg ? -r_lo : r_lo;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (both) state_nx = CALC;
         CALC:    if (last) state_nx = FIX;
         FIX:     state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture, iteration and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         dvd_cap            <= 1'b0;
         dvs_cap            <= 1'b0;
         dvd_q              <= '0;
         dvs_q              <= '0;
         rem                <= '0;
         quo                <= '0;
         dvs_m              <= '0;
         q_neg              <= 1'b0;
         r_neg              <= 1'b0;
         cnt                <= '0;
         m_axis_dout_tdata  <= '0;
         m_axis_dout_tvalid <= 1'b0;
      end else begin
         m_axis_dout_tvalid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (dvd_hs) begin
                  dvd_q   <= s_axis_dividend_tdata;
                  dvd_cap <= 1'b1;
               end
               if (dvs_hs) begin
                  dvs_q   <= s_axis_divisor_tdata;
                  dvs_cap <= 1'b1;
               end
               if (both) begin
                  rem   <= '0;
                  quo   <= dvd_mag;
                  dvs_m <= dvs_mag;
                  q_neg <= dvd_neg ^ dvs_neg;
                  r_neg <= dvd_neg;
                  cnt   <= '0;
               end
            end
            CALC: begin
               rem <= fits ? diff[WIDTH:0] : shifted;
               quo <= {quo[WIDTH-2:0], fits};
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               m_axis_dout_tdata  <= {q_fix, r_fix};
               m_axis_dout_tvalid <= 1'b1;
            end
            DONE: begin
               dvd_cap <= 1'b0;
               dvs_cap <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_div_axis.sv
// tb_iter_div_axis: directed checks of the divider, one unsigned and one
// signed instance sharing clock and reset.
module tb_iter_div_axis;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] dvd_d [2];
   logic        dvd_v [2];
   logic        dvd_r [2];
   logic [31:0] dvs_d [2];
   logic        dvs_v [2];
   logic        dvs_r [2];
   logic [63:0] dout  [2];
   logic        vld   [2];

   int total = 0;
   int bad   = 0;

   iter_div_axis #(.WIDTH(32), .SIGNED(1'b0)) u_udiv (
      .clk                    (clk),
      .reset                  (reset),
      .s_axis_dividend_tdata  (dvd_d[0]),
      .s_axis_dividend_tvalid (dvd_v[0]),
      .s_axis_dividend_tready (dvd_r[0]),
      .s_axis_divisor_tdata   (dvs_d[0]),
      .s_axis_divisor_tvalid  (dvs_v[0]),
      .s_axis_divisor_tready  (dvs_r[0]),
      .m_axis_dout_tdata      (dout[0]),
      .m_axis_dout_tvalid     (vld[0])
   );

   iter_div_axis #(.WIDTH(32), .SIGNED(1'b1)) u_sdiv (
      .clk                    (clk),
      .reset                  (reset),
      .s_axis_dividend_tdata  (dvd_d[1]),
      .s_axis_dividend_tvalid (dvd_v[1]),
      .s_axis_dividend_tready (dvd_r[1]),
      .s_axis_divisor_tdata   (dvs_d[1]),
      .s_axis_divisor_tvalid  (dvs_v[1]),
      .s_axis_divisor_tready  (dvs_r[1]),
      .m_axis_dout_tdata      (dout[1]),
      .m_axis_dout_tvalid     (vld[1])
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] rdy(input int s);
      return {62'b0, dvd_r[s], dvs_r[s]};
   endfunction

   task automatic wait_pulse(input int s, input int lim, output int n);
      n = -1;
      for (int k = 1; k <= lim; k++) begin
         tick();
         if (vld[s]) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic run(input int s, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] exp,
                      input string tag);
      int n;
      dvd_d[s] = a;
      dvs_d[s] = b;
      dvd_v[s] = 1'b1;
      dvs_v[s] = 1'b1;
      chk({tag, ".rdy"}, rdy(s), 64'd3);
      tick();
      dvd_v[s] = 1'b0;
      dvs_v[s] = 1'b0;
      chk({tag, ".busy"}, rdy(s), 64'd0);
      wait_pulse(s, 60, n);
      chk({tag, ".lat"}, 64'(n), 64'd33);
      chk({tag, ".data"}, dout[s], exp);
      tick();
      chk({tag, ".pulse"}, {63'b0, vld[s]}, 64'd0);
      chk({tag, ".idle"}, rdy(s), 64'd3);
      chk({tag, ".hold"}, dout[s], exp);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int n2;
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         dvd_d[i] = '0;
         dvs_d[i] = '0;
         dvd_v[i] = 1'b0;
         dvs_v[i] = 1'b0;
      end
      tick();
      tick();
      for (int i = 0; i < 2; i++) begin
         chk("rst.rdy", rdy(i), 64'd3);
         chk("rst.vld", {63'b0, vld[i]}, 64'd0);
         chk("rst.dout", dout[i], 64'd0);
      end
      reset = 1'b0;
      tick();

      run(0, 32'd100, 32'd7, {32'd14, 32'd2}, "u100_7");
      run(0, 32'h12345678, 32'd0, {32'hFFFFFFFF, 32'h12345678}, "u_div0");
      run(0, 32'hFFFFFFFF, 32'd1, {32'hFFFFFFFF, 32'd0}, "u_max");
      run(1, 32'd7, 32'd2, {32'd3, 32'd1}, "s7_2");
      run(1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFD, 32'hFFFFFFFF}, "sm7_2");
      run(1, 32'd7, 32'hFFFFFFFE, {32'hFFFFFFFD, 32'h00000001}, "s7_m2");
      run(1, 32'hFFFFFFF9, 32'hFFFFFFFE, {32'd3, 32'hFFFFFFFF}, "sm7_m2");
      run(1, 32'hFFFFFFFB, 32'd0, {32'd1, 32'hFFFFFFFB}, "s_div0");
      run(1, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0}, "s_ovf");

      // staggered operands
      dvd_d[1] = 32'd50;
      dvd_v[1] = 1'b1;
      tick();
      dvd_v[1] = 1'b0;
      chk("stag.rdy0", rdy(1), 64'd1);
      for (int i = 0; i < 4; i++) tick();
      chk("stag.rdy4", rdy(1), 64'd1);
      dvs_d[1] = 32'd7;
      dvs_v[1] = 1'b1;
      tick();
      dvs_v[1] = 1'b0;
      chk("stag.busy", rdy(1), 64'd0);
      wait_pulse(1, 60, n);
      chk("stag.lat", 64'(n), 64'd33);
      chk("stag.data", dout[1], {32'd7, 32'd1});
      tick();

      // reset mid-calculation
      dvd_d[1] = 32'd1000;
      dvs_d[1] = 32'd3;
      dvd_v[1] = 1'b1;
      dvs_v[1] = 1'b1;
      tick();
      dvd_v[1] = 1'b0;
      dvs_v[1] = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort.rdy", rdy(1), 64'd3);
      chk("abort.vld", {63'b0, vld[1]}, 64'd0);
      chk("abort.dout", dout[1], 64'd0);
      wait_pulse(1, 50, n);
      chk("abort.nopulse", 64'(n), 64'hFFFFFFFFFFFFFFFF);
      run(1, 32'd9, 32'd3, {32'd3, 32'd0}, "after_abort");

      // back-to-back with operands held valid
      dvd_d[0] = 32'd20;
      dvs_d[0] = 32'd6;
      dvd_v[0] = 1'b1;
      dvs_v[0] = 1'b1;
      tick();
      dvd_d[0] = 32'hFFFFFFFF;
      dvs_d[0] = 32'd1;
      chk("b2b.busy", rdy(0), 64'd0);
      wait_pulse(0, 60, n);
      chk("b2b.lat1", 64'(n), 64'd33);
      chk("b2b.data1", dout[0], {32'd3, 32'd2});
      tick();
      chk("b2b.idle", rdy(0), 64'd3);
      tick();
      chk("b2b.acc", rdy(0), 64'd0);
      dvd_v[0] = 1'b0;
      dvs_v[0] = 1'b0;
      wait_pulse(0, 60, n2);
      chk("b2b.gap", 64'(n2 + 2), 64'd35);
      chk("b2b.data2", dout[0], {32'hFFFFFFFF, 32'd0});
      tick();
      chk("b2b.pulse", {63'b0, vld[0]}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
